mac_sequencer: RTL
==================

# mac_sequencer

Control-plus-datapath stage that sits directly downstream of the A/B/C memory unit in the pipelined MAC. It walks every (i, j, k) index triple of C = A·B. It issues one A/B element read per cycle to the memory unit and multiply-accumulates the returned elements in a 3-stage pipeline. Each finished C element is written back to the memory unit one at a time, and a full C readout is requested once the last element has landed.

## Interface
Parameters:
- param_M, 4, rows of A and C
- param_K, 4, columns of A / rows of B (reduction length)
- param_N, 4, columns of B and C
- DATA_WIDTH_INITIAL, 8, A/B element width (unsigned)
- DATA_WIDTH_FINAL, DATA_WIDTH_INITIAL*2, C element / accumulator width

Ports:
- clk  in  1  clock
- rstn  in  1  reset: rstn, asynchronous, active-low; clock clk
- start  in  1  request to compute C; sampled only in IDLE
- busy  out  1  high from the first RUN cycle through the done cycle
- done  out  1  one-cycle pulse; the memory unit's C readout is valid in this cycle
- a_addr  out  $clog2(M*K)  A element address, a_addr = i*K+k
- b_addr  out  $clog2(K*N)  B element address, b_addr = k*N+j
- a_b_re  out  1  A/B read strobe
- a_data_in  in  DATA_WIDTH_INITIAL  A element, valid the cycle after a_b_re
- b_data_in  in  DATA_WIDTH_INITIAL  B element, valid the cycle after a_b_re
- c_addr  out  $clog2(M*N)  C element address, c_addr = i*N+j
- c_data  out  DATA_WIDTH_FINAL  completed C element
- c_we  out  1  C element write strobe
- c_re  out  1  one-cycle full-C read strobe

## Operation
- **FSM states:**
  - IDLE: waits for start.
  - RUN: issues one read per cycle.
  - DRAIN: waits until all pipeline valid bits are 0.
  - READ: asserts c_re for one cycle.
  - DONE: pulses done.
- **Transitions:**
  - IDLE→RUN on start.
  - RUN→DRAIN after the issue with i=M-1, j=N-1, k=K-1.
  - DRAIN→READ when the pipeline is empty.
  - READ→DONE and DONE→IDLE unconditionally.
- **Loop order:** i outermost, then j, then k innermost; all counters zero on RUN entry.
- **Pipeline stages:**
  - Stage 0 (RUN cycle): drive a_addr, b_addr and a_b_re=1. Tag the issue with valid, first (k==0), last (k==K-1) and c_addr.
  - Stage 1: the memory returns data; register tags only.
  - Stage 2: register p = a_data_in*b_data_in (unsigned, 2*DATA_WIDTH_INITIAL bits).
  - Stage 3: acc <= first ? p : acc+p. If last, register c_we=1, c_addr=tag, c_data=the same new acc value.
- **Arithmetic:** p is zero-extended or truncated to DATA_WIDTH_FINAL. Accumulation wraps modulo 2^DATA_WIDTH_FINAL; there is no saturation and no overflow flag.
- **K=1:** first and last are both true on every issue; every product is written directly.
- **start while busy:** ignored, including in the DONE cycle.
- **Reset:** asynchronous reset at any time returns the block to IDLE and clears every pipeline valid bit and strobe. A partially written C is left in memory; no recovery.
- **Output hold:** a_addr, b_addr, c_addr and c_data hold their last value when their strobes are low.

## Timing
- Reset values: busy=0, done=0, a_b_re=0, c_we=0, c_re=0, a_addr=0, b_addr=0, c_addr=0, c_data=0, acc=0; state=IDLE.
- Cycle reference: start is high in cycle 0. The first issue is in cycle 1, and issue n occurs in cycle n, for n=1..M*N*K.
- Per-issue latency: issue n's operands arrive in cycle n+1, p is valid in cycle n+2, and any resulting c_we is visible in cycle n+3.
- Default 4×4×4 run:
  - Reads issued in cycles 1–64.
  - c_we pulses in cycles 7, 11, …, 67 (16 pulses).
  - DRAIN covers cycles 65–67.
  - c_re in cycle 68.
  - done in cycle 69.
  - IDLE from cycle 70.
- General formula: c_re occurs in cycle M*N*K+4 and done in cycle M*N*K+5. busy is high in cycles 1 through M*N*K+5.
- Throughput: one A/B read per RUN cycle with no bubbles; c_we is never high in two consecutive cycles when K>1.

## Structure
- **Package mac_pkg:**
  - typedef enum for the FSM states.
  - a stage-tag struct (valid, first, last, c_addr).
  - address-width localparam helpers.
- **Sub-module mac_pipe:** stages 1–3, i.e. the tag shift, multiplier register and accumulator/writeback register.
- **mac_sequencer:** keeps the FSM and the i/j/k counters.

## Test plan
- A = 4×4 identity, B[e] = e (0..15), start → 16 c_we writes with c_data = e at c_addr = e; c_re in cycle 68; done in cycle 69.
- A and B all 1 → every c_data = 4; c_we pulses in cycles 7, 11, …, 67.
- A and B all 255 → every c_data = 63492 (260100 mod 65536), confirming accumulator wrap.
- Pulse start again in cycles 5 and 69 → no effect. A fresh start in cycle 70 repeats the identical sequence, with the first read in cycle 71.
- Deassert rstn in cycle 30 → all outputs 0 and state IDLE immediately, with no further c_we or c_re. The next start runs the full sequence normally.
- Parameters M=2, K=1, N=3 → 6 reads; each c_data = a[i]*b[j]; c_re in cycle 10; done in cycle 11.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types for the MAC sequencer: FSM states, the per-issue pipeline tag,
// and the address-width helper used for all element address ports.
package mac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_READ,
        S_DONE
    } state_t;

    // Wide enough for any C matrix this block is expected to walk.
    localparam int TAG_ADDR_W = 16;

    typedef struct packed {
        logic                  valid;
        logic                  first;
        logic                  last;
        logic [TAG_ADDR_W-1:0] c_addr;
    } tag_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mac_pipe.sv
// Stages 1-3 of the MAC: tag delay line, product register, and the
// accumulator with its C write-back register.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH_INITIAL = 8,
    parameter int DATA_WIDTH_FINAL   = 16,
    parameter int C_ADDR_W           = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  tag_t                          tag_in,
    input  logic [DATA_WIDTH_INITIAL-1:0] a_data_in,
    input  logic [DATA_WIDTH_INITIAL-1:0] b_data_in,
    output logic                          empty,
    output logic                          c_we,
    output logic [C_ADDR_W-1:0]           c_addr,
    output logic [DATA_WIDTH_FINAL-1:0]   c_data
);

    localparam int PROD_W = 2 * DATA_WIDTH_INITIAL;

    tag_t                        tag1;
    tag_t                        tag2;
    logic [PROD_W-1:0]           p;
    logic [DATA_WIDTH_FINAL-1:0] acc;
    logic [DATA_WIDTH_FINAL-1:0] p_ext;
    logic [DATA_WIDTH_FINAL-1:0] acc_next;

    // Tag addresses are carried at full package width; only the low bits address C.
    logic unused_tag_bits;
    assign unused_tag_bits = ^tag2.c_addr[TAG_ADDR_W-1:C_ADDR_W];

    assign empty = !tag1.valid && !tag2.valid;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        p_ext    = DATA_WIDTH_FINAL'(p);
        acc_next = tag2.first ? p_ext : acc + p_ext;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag1   <= '0;
            tag2   <= '0;
            p      <= '0;
            acc    <= '0;
            c_we   <= 1'b0;
            c_addr <= '0;
            c_data <= '0;
        end else begin
            tag1 <= tag_in;
            tag2 <= tag1;
            p    <= PROD_W'(a_data_in) * PROD_W'(b_data_in);
            c_we <= 1'b0;
            if (tag2.valid) begin
                acc <= acc_next;
                if (tag2.last) begin
                    c_we   <= 1'b1;
                    c_addr <= tag2.c_addr[C_ADDR_W-1:0];
                    c_data <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Walks every (i, j, k) of C = A*B, issuing one A/B read per cycle, then
// drains the MAC pipeline, requests a full C readout and pulses done.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int param_M            = 4,
    parameter int param_K            = 4,
    parameter int param_N            = 4,
    parameter int DATA_WIDTH_INITIAL = 8,
    parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2,
    localparam int A_W = addr_w(param_M * param_K),
    localparam int B_W = addr_w(param_K * param_N),
    localparam int C_W = addr_w(param_M * param_N)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [A_W-1:0]                a_addr,
    output logic [B_W-1:0]                b_addr,
    output logic                          a_b_re,
    input  logic [DATA_WIDTH_INITIAL-1:0] a_data_in,
    input  logic [DATA_WIDTH_INITIAL-1:0] b_data_in,
    output logic [C_W-1:0]                c_addr,
    output logic [DATA_WIDTH_FINAL-1:0]   c_data,
    output logic                          c_we,
    output logic                          c_re
);

    localparam int I_W = addr_w(param_M);
    localparam int J_W = addr_w(param_N);
    localparam int K_W = addr_w(param_K);

    state_t         state;
    logic [I_W-1:0] i, ni, iss_i;
    logic [J_W-1:0] j, nj, iss_j;
    logic [K_W-1:0] k, nk, iss_k;
    logic           last_i, last_j, last_k, last_triple;
    logic [A_W-1:0] iss_a_addr;
    logic [B_W-1:0] iss_b_addr;
    tag_t           iss_tag;
    tag_t           tag0;
    logic           pipe_empty;

    assign a_b_re = tag0.valid;

    // Counters hold the triple currently on the read bus; the next triple is issued from ni/nj/nk.
    always_comb begin
        last_i      = (i == I_W'(param_M - 1));
        last_j      = (j == J_W'(param_N - 1));
        last_k      = (k == K_W'(param_K - 1));
        last_triple = last_i && last_j && last_k;
        nk          = last_k ? '0 : k + K_W'(1);
        nj          = last_k ? (last_j ? '0 : j + J_W'(1)) : j;
        ni          = (last_k && last_j) ? i + I_W'(1) : i;

        iss_i = '0;
        iss_j = '0;
        iss_k = '0;
        if (state == S_RUN) begin
            iss_i = ni;
            iss_j = nj;
            iss_k = nk;
        end
        iss_a_addr     = A_W'(int'(iss_i) * param_K + int'(iss_k));
        iss_b_addr     = B_W'(int'(iss_k) * param_N + int'(iss_j));
        iss_tag.valid  = 1'b1;
        iss_tag.first  = (iss_k == '0);
        iss_tag.last   = (iss_k == K_W'(param_K - 1));
        iss_tag.c_addr = TAG_ADDR_W'(int'(iss_i) * param_N + int'(iss_j));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            a_addr <= '0;
            b_addr <= '0;
            tag0   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            c_re   <= 1'b0;
        end else begin
            tag0.valid <= 1'b0;
            done       <= 1'b0;
            c_re       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        a_addr <= iss_a_addr;
                        b_addr <= iss_b_addr;
                        tag0   <= iss_tag;
                    end
                end
                S_RUN: begin
                    if (last_triple) begin
                        state <= S_DRAIN;
                    end else begin
                        i      <= ni;
                        j      <= nj;
                        k      <= nk;
                        a_addr <= iss_a_addr;
                        b_addr <= iss_b_addr;
                        tag0   <= iss_tag;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state <= S_READ;
                        c_re  <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    mac_pipe #(
        .DATA_WIDTH_INITIAL(DATA_WIDTH_INITIAL),
        .DATA_WIDTH_FINAL  (DATA_WIDTH_FINAL),
        .C_ADDR_W          (C_W)
    ) u_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .tag_in   (tag0),
        .a_data_in(a_data_in),
        .b_data_in(b_data_in),
        .empty    (pipe_empty),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_data   (c_data)
    );

endmodule
